// File: rtl/vc_tx_pkg.sv
// rtl/vc_tx_pkg.sv - shared flit type and FSM state encodings for the credit transmitter
package vc_tx_pkg;

  localparam int FLIT_SIZE = 16;

  typedef logic [1:FLIT_SIZE] flit_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/vc_tx_if.sv
// rtl/vc_tx_if.sv - upstream flit stream plus downstream vc load/credit bundle
interface vc_tx_if #(
  parameter int CNT_W = 16
);
  import vc_tx_pkg::*;

  flit_t            in_flit;
  logic             in_valid;
  logic             in_ready;
  flit_t            flit_out;
  logic             load;
  logic             vc_credit;
  logic             busy;
  logic [CNT_W-1:0] sent_count;

  modport slave (
    input  in_flit, in_valid, vc_credit,
    output in_ready, flit_out, load, busy, sent_count
  );

  modport master (
    output in_flit, in_valid, vc_credit,
    input  in_ready, flit_out, load, busy, sent_count
  );

endinterface

// File: rtl/vc_tx_fifo.sv
// rtl/vc_tx_fifo.sv - small flit queue with combinational head; caller guards push/pop
module vc_tx_fifo
  import vc_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  flit_t           din,
  output flit_t           dout,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  flit_t             mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_tx.sv
// rtl/vc_tx.sv - credit-based transmitter feeding one downstream vc buffer
module vc_tx
  import vc_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2,
  parameter int CNT_W      = 16
) (
  input  logic    clock,
  input  logic    reset,
  vc_tx_if.slave  bus
);

  state_t           state_q, state_d;
  flit_t            flit_q, flit_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push, pop, full, empty;
  flit_t            head;
  logic [ADDR_W:0]  count;

  // in_ready is !full from the registered count, so a same-cycle pop never frees a slot.
  assign push = bus.in_valid && !full;

  vc_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_flit),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    load_d  = 1'b0;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 && bus.vc_credit) begin
          flit_d  = head;
          load_d  = 1'b1;
          pop     = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT_LOW;
        end
      end
      // Credit still reads 1 right after load; wait for it to drop before trusting a rise.
      WAIT_LOW: begin
        if (!bus.vc_credit) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.vc_credit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      flit_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.flit_out   = flit_q;
  assign bus.load       = load_q;
  assign bus.busy       = !empty || (state_q != IDLE);
  assign bus.sent_count = cnt_q;

endmodule

// File: tb/tb_vc_tx.sv
// tb/tb_vc_tx.sv - directed bench with a credit-returning vc model and flit scoreboard
module tb_vc_tx;
  import vc_tx_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vc_tx_if #(.CNT_W(16)) bus ();

  vc_tx #(
    .FIFO_DEPTH (4),
    .ADDR_W     (2),
    .CNT_W      (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic       model_en      = 1'b0;
  logic       forced_credit = 1'b1;
  logic [1:0] phase;
  logic       model_credit, armed, prev_credit, prev_load;
  int         violations = 0;
  int         loads_seen = 0;
  flit_t      got[$];
  flit_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;

  // Downstream vc: credit stays 1 for one cycle after capturing load, then 0 for two cycles.
  assign model_credit  = (phase == 2'd0) || (phase == 2'd3);
  assign bus.vc_credit = model_en ? model_credit : forced_credit;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      phase       <= 2'd0;
      armed       <= 1'b1;
      prev_credit <= 1'b1;
      prev_load   <= 1'b0;
    end else begin
      prev_load   <= bus.load;
      prev_credit <= bus.vc_credit;
      if (bus.load) begin
        got.push_back(bus.flit_out);
        loads_seen <= loads_seen + 1;
        if (!armed || prev_load) violations <= violations + 1;
        armed <= 1'b0;
        phase <= 2'd3;
      end else begin
        if (phase != 2'd0) phase <= phase - 2'd1;
        if (!prev_credit && bus.vc_credit) armed <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_flit(flit_t f);
    bus.in_flit  = f;
    bus.in_valid = 1'b1;
    if (bus.in_ready) exp_q.push_back(f);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_got(int n, int base);
    int k = 0;
    while ((got.size() - base) < n && k < 300) begin
      tick();
      k++;
    end
    check("wait_got", 32'(got.size() - base), 32'(n));
  endtask

  initial begin
    int base;
    int l0;
    int v0;
    bus.in_flit  = '0;
    bus.in_valid = 1'b0;

    // Reset then idle
    repeat (2) tick();
    check("rst_load", 32'(bus.load), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_load", 32'(bus.load), 32'd0);
    check("idle_flit", 32'(bus.flit_out), 32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_sent", 32'(bus.sent_count), 32'd0);

    // Single flit: written at edge 1, load visible after edge 2
    model_en = 1'b1;
    base = got.size();
    l0   = loads_seen;
    v0   = violations;
    exp_q.delete();
    push_flit(flit_t'(16'h00A5));
    check("single_no_load_yet", 32'(bus.load), 32'd0);
    check("single_busy", 32'(bus.busy), 32'd1);
    tick();
    check("single_load", 32'(bus.load), 32'd1);
    check("single_flit", 32'(bus.flit_out), 32'h00A5);
    check("single_sent", 32'(bus.sent_count), 32'd1);
    tick();
    check("single_load_drop", 32'(bus.load), 32'd0);
    check("single_flit_hold", 32'(bus.flit_out), 32'h00A5);
    wait_got(1, base);
    if (got.size() > base) check("single_sb", 32'(got[base]), 32'(exp_q[0]));
    repeat (20) tick();
    check("single_one_load", 32'(loads_seen - l0), 32'd1);
    check("single_proto", 32'(violations - v0), 32'd0);

    // Burst fills the FIFO, then a push against full while a pop happens
    do_reset();
    model_en      = 1'b0;
    forced_credit = 1'b0;
    base = got.size();
    v0   = violations;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      check("burst_ready", 32'(bus.in_ready), 32'd1);
      push_flit(flit_t'(i));
    end
    check("burst_full", 32'(bus.in_ready), 32'd0);
    check("burst_busy", 32'(bus.busy), 32'd1);
    bus.in_flit  = flit_t'(16'h0005);
    bus.in_valid = 1'b1;
    check("full_no_write", 32'(bus.in_ready), 32'd0);
    model_en = 1'b1;
    tick();
    check("ready_after_pop", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(flit_t'(16'h0005));
    tick();
    bus.in_valid = 1'b0;
    wait_got(5, base);
    for (int i = 0; i < 5; i++) begin
      if (got.size() > base + i) check("burst_sb", 32'(got[base+i]), 32'(exp_q[i]));
    end
    repeat (10) tick();
    check("burst_sent", 32'(bus.sent_count), 32'd5);
    check("burst_proto", 32'(violations - v0), 32'd0);
    check("burst_idle", 32'(bus.busy), 32'd0);

    // Stale credit: constant 1 must not release a second flit
    do_reset();
    model_en      = 1'b0;
    forced_credit = 1'b1;
    l0 = loads_seen;
    push_flit(flit_t'(16'h0011));
    push_flit(flit_t'(16'h0022));
    repeat (10) tick();
    check("stale_loads", 32'(loads_seen - l0), 32'd1);
    check("stale_sent", 32'(bus.sent_count), 32'd1);
    check("stale_state", 32'(dut.state_q), 32'(WAIT_LOW));
    check("stale_busy", 32'(bus.busy), 32'd1);

    // Reset while in WAIT_HIGH with three flits queued
    do_reset();
    forced_credit = 1'b1;
    for (int i = 0; i < 4; i++) push_flit(flit_t'(16'h0031 + i));
    forced_credit = 1'b0;
    tick();
    check("mid_state", 32'(dut.state_q), 32'(WAIT_HIGH));
    reset = 1'b1;
    #1;
    check("mid_rst_load", 32'(bus.load), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sent", 32'(bus.sent_count), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    reset         = 1'b0;
    forced_credit = 1'b1;
    l0 = loads_seen;
    repeat (10) tick();
    check("mid_no_stale", 32'(loads_seen - l0), 32'd0);
    check("mid_sent", 32'(bus.sent_count), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
